// File: rtl/ifmap_spad_ctrl.sv
//------------------------------------------------------------------------------
// ifmap_spad_ctrl : loads an ifmap row into a scratchpad, then streams every
//                   sliding filter window (pos-major, k-minor) from it.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifmap_spad_ctrl #(
    parameter int DEPTH = 12,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    cfg_len,
    input  logic [3:0]    cfg_win,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [3:0]    spad_addr,
    output logic          spad_we,
    output logic [DW-1:0] spad_wdata,
    input  logic [DW-1:0] spad_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [4:0] c_depth = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    win_q, win_d;
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    pos_q, pos_d;
    logic [3:0]    k_q, k_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          err_q, err_d;

    logic          w_cfg_ok;
    logic [3:0]    w_rd_addr;
    logic          w_last_k;

    assign w_cfg_ok  = (cfg_len != 4'd0) && ({1'b0, cfg_len} <= c_depth) &&
                       (cfg_win != 4'd0) && (cfg_win <= cfg_len);
    // pos <= len-win and k <= win-1 keep this below len, so no wrap is possible
    assign w_rd_addr = pos_q + k_q;
    assign w_last_k  = (k_q == win_q - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 4'd0;
            win_q      <= 4'd0;
            wr_ptr_q   <= 4'd0;
            pos_q      <= 4'd0;
            k_q        <= 4'd0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            win_q      <= win_d;
            wr_ptr_q   <= wr_ptr_d;
            pos_q      <= pos_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        win_d      = win_q;
        wr_ptr_d   = wr_ptr_q;
        pos_d      = pos_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
        in_ready   = 1'b0;
        spad_we    = 1'b0;
        spad_addr  = 4'd0;
        spad_wdata = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        state_d  = S_LOAD;
                        len_d    = cfg_len;
                        win_d    = cfg_win;
                        wr_ptr_d = 4'd0;
                        pos_d    = 4'd0;
                        k_d      = 4'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                spad_addr = wr_ptr_q;
                if (in_valid) begin
                    spad_we    = 1'b1;
                    spad_wdata = in_data;
                    wr_ptr_d   = wr_ptr_q + 4'd1;
                    if (wr_ptr_q == len_q - 4'd1) begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                spad_addr = w_rd_addr;
                state_d   = S_CAP;
            end
            S_CAP: begin
                // read data for the address issued in RD is present this cycle
                spad_addr  = w_rd_addr;
                out_data_d = spad_rdata;
                state_d    = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = w_last_k;
                if (out_ready) begin
                    if (!w_last_k) begin
                        k_d     = k_q + 4'd1;
                        state_d = S_RD;
                    end else if (pos_q < len_q - win_q) begin
                        k_d     = 4'd0;
                        pos_d   = pos_q + 4'd1;
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign err      = err_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_LOAD) || (state_q == S_RD) ||
                      (state_q == S_CAP)  || (state_q == S_OUT);

endmodule

`default_nettype wire

// File: tb/tb_ifmap_spad_ctrl.sv
//------------------------------------------------------------------------------
// tb_ifmap_spad_ctrl : self-checking bench for ifmap_spad_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ifmap_spad_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    cfg_len = 4'd0;
    logic [3:0]    cfg_win = 4'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    spad_addr;
    logic          spad_we;
    logic [DW-1:0] spad_wdata;
    logic [DW-1:0] spad_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    ifmap_spad_ctrl #(.DEPTH(12), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_win(cfg_win),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .spad_addr(spad_addr), .spad_we(spad_we), .spad_wdata(spad_wdata),
        .spad_rdata(spad_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // scratchpad with one-cycle registered read
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        if (spad_we) mem[spad_addr] <= spad_wdata;
        spad_rdata <= mem[spad_addr];
    end

    int nchk = 0;
    int nerr = 0;
    logic [DW-1:0] words [16];
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];
    int            cur_len = 16;
    int            rdy_mode = 0;

    // observation side: only this process writes these
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            acc_cyc [$];
    int            cyc = 0, done_cnt = 0, err_cnt = 0, we_cnt = 0;
    int            stab_viol = 0, addr_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (out_valid && prev_stall && (out_data !== prev_d || out_last !== prev_l))
                stab_viol++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                acc_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (spad_we) we_cnt++;
            if (busy && int'(spad_addr) >= cur_len) addr_viol++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int seen = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (got_d.size() != seen) begin
            seen      = got_d.size();
            stall_cnt = 0;
        end
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = out_valid && (stall_cnt >= 4);
                if (out_valid && stall_cnt < 4) stall_cnt++;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // reference: every window position, every tap, data = word[pos+k]
    function automatic void build_exp(input int len, input int win);
        exp_d.delete();
        exp_l.delete();
        for (int p = 0; p <= len - win; p++)
            for (int k = 0; k < win; k++) begin
                exp_d.push_back(words[p + k]);
                exp_l.push_back(k == win - 1);
            end
    endfunction

    task automatic start_and_load(input int len, input int win, input bit rand_valid, input bit poke);
        int idx, guard;
        cur_len = len;
        build_exp(len, win);
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 4'(len); cfg_win = 4'(win);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < len && guard < 500) begin
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = words[idx];
            if (poke && idx == 1) begin start = 1'b1; cfg_len = 4'd0; end
            else start = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < len) begin
            nchk++; nerr++;
            $display("FAIL load_timeout: loaded %0d words, required %0d", idx, len);
        end
    endtask

    task automatic wait_done(input int d0, input bit poke);
        bit poked = 1'b0;
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) break;
            if (poke && out_valid && !poked) begin
                @(posedge clk); #1;
                start = 1'b1; cfg_len = 4'd3; cfg_win = 4'd1;
                @(posedge clk); #1;
                start = 1'b0;
                poked = 1'b1;
            end
        end
        if (n >= 3000) begin
            nchk++; nerr++;
            $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic test_reset();
        logic [7+4+2*DW-1:0] ov;
        int b, d0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        start = 1'b1; cfg_len = 4'd1; cfg_win = 4'd1; in_valid = 1'b1; in_data = 16'hA5A5;
        #1;
        ov = {in_ready, spad_we, out_valid, out_last, busy, done, err, spad_addr, spad_wdata, out_data};
        nchk++;
        if (ov !== '0) begin nerr++; $display("FAIL reset_async: outputs=%h required 0", ov); end
        repeat (3) @(negedge clk);
        ov = {in_ready, spad_we, out_valid, out_last, busy, done, err, spad_addr, spad_wdata, out_data};
        nchk++;
        if (ov !== '0) begin nerr++; $display("FAIL reset_hold: outputs=%h required 0", ov); end
        words[0] = 16'hA5A5;
        build_exp(1, 1);
        cur_len = 1;
        b = got_d.size(); d0 = done_cnt;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        nchk++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_first_start: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        nchk++;
        if (spad_we !== 1'b1 || spad_wdata !== 16'hA5A5 || spad_addr !== 4'd0) begin
            nerr++; $display("FAIL reset_first_write: we=%b addr=%0d wdata=%h required 1 0 a5a5",
                             spad_we, spad_addr, spad_wdata);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(d0, 1'b0);
        nchk++;
        if (got_d.size() - b != 1 || got_d[b] !== exp_d[0] || got_l[b] !== exp_l[0]) begin
            nerr++; $display("FAIL reset_job: elements=%0d first=%h required 1 %h",
                             got_d.size() - b, got_d[b], exp_d[0]);
        end
    endtask

    task automatic test_basic();
        int b, d0, bad_gap;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) words[i] = DW'(10 * (i + 1));
        b = got_d.size(); d0 = done_cnt;
        start_and_load(5, 3, 1'b0, 1'b0);
        wait_done(d0, 1'b0);
        nchk++;
        if (got_d.size() - b != 9) begin nerr++; $display("FAIL basic_count: got %0d required 9", got_d.size() - b); end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            nchk++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                nerr++; $display("FAIL basic_elem%0d: data=%0d last=%b required %0d %b",
                                 i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        bad_gap = 0;
        for (int i = 1; i < 9 && b + i < acc_cyc.size(); i++)
            if (acc_cyc[b+i] - acc_cyc[b+i-1] != 3) bad_gap++;
        nchk++;
        if (bad_gap != 0) begin nerr++; $display("FAIL basic_throughput: %0d gaps not 3 cycles, required 0", bad_gap); end
        nchk++;
        if (done_cnt - d0 != 1) begin nerr++; $display("FAIL basic_done: done pulses %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_full_window();
        int b, d0, a0;
        rdy_mode = 0;
        for (int i = 0; i < 12; i++) words[i] = DW'(i + 1);
        b = got_d.size(); d0 = done_cnt; a0 = addr_viol;
        start_and_load(12, 12, 1'b0, 1'b0);
        wait_done(d0, 1'b0);
        nchk++;
        if (got_d.size() - b != 12) begin nerr++; $display("FAIL full_count: got %0d required 12", got_d.size() - b); end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            nchk++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                nerr++; $display("FAIL full_elem%0d: data=%0d last=%b required %0d %b",
                                 i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        nchk++;
        if (addr_viol != a0) begin nerr++; $display("FAIL full_addr: %0d out-of-range addresses, required 0", addr_viol - a0); end
    endtask

    task automatic test_invalid();
        logic [3:0] lens [3];
        logic [3:0] wins [3];
        int w0, e0;
        lens[0] = 4'd13; wins[0] = 4'd3;
        lens[1] = 4'd4;  wins[1] = 4'd5;
        lens[2] = 4'd4;  wins[2] = 4'd0;
        w0 = we_cnt; e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b1; cfg_len = lens[i]; cfg_win = wins[i];
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            nchk++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                nerr++; $display("FAIL invalid%0d_err: err=%b busy=%b required 1 0", i, err, busy);
            end
            @(negedge clk);
            nchk++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                nerr++; $display("FAIL invalid%0d_pulse: err=%b busy=%b required 0 0", i, err, busy);
            end
        end
        #1;
        nchk++;
        if (we_cnt != w0 || err_cnt - e0 != 3) begin
            nerr++; $display("FAIL invalid_side: writes=%0d errs=%0d required 0 3", we_cnt - w0, err_cnt - e0);
        end
    endtask

    task automatic test_stall();
        int b, d0, s0;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) words[i] = DW'(i + 1);
        b = got_d.size(); d0 = done_cnt; s0 = stab_viol;
        start_and_load(3, 2, 1'b1, 1'b0);
        wait_done(d0, 1'b0);
        nchk++;
        if (got_d.size() - b != 4) begin nerr++; $display("FAIL stall_count: got %0d required 4", got_d.size() - b); end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            nchk++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                nerr++; $display("FAIL stall_elem%0d: data=%0d last=%b required %0d %b",
                                 i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        nchk++;
        if (stab_viol != s0) begin nerr++; $display("FAIL stall_stable: %0d changes while stalled, required 0", stab_viol - s0); end
        rdy_mode = 0;
    endtask

    task automatic test_reset_midjob();
        logic [7+4+2*DW-1:0] ov;
        int b, d0, n;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) words[i] = DW'(16'h100 + i);
        b = got_d.size(); d0 = done_cnt;
        start_and_load(4, 2, 1'b0, 1'b0);
        for (n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (got_d.size() - b >= 2) break;
        end
        nchk++;
        if (n >= 100 || !out_valid) begin
            nerr++; $display("FAIL midjob_reach: elements=%0d out_valid=%b required 2 1", got_d.size() - b, out_valid);
        end
        rst_n = 1'b0;
        #1;
        ov = {in_ready, spad_we, out_valid, out_last, busy, done, err, spad_addr, spad_wdata, out_data};
        nchk++;
        if (ov !== '0) begin nerr++; $display("FAIL midjob_reset: outputs=%h required 0", ov); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        nchk++;
        if (done_cnt != d0) begin nerr++; $display("FAIL midjob_nodone: done pulses %0d required 0", done_cnt - d0); end
        for (int i = 0; i < 4; i++) words[i] = DW'(16'h200 + 3 * i);
        b = got_d.size(); d0 = done_cnt;
        start_and_load(4, 2, 1'b0, 1'b0);
        wait_done(d0, 1'b0);
        nchk++;
        if (got_d.size() - b != 6) begin nerr++; $display("FAIL midjob_count: got %0d required 6", got_d.size() - b); end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            nchk++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                nerr++; $display("FAIL midjob_elem%0d: data=%h last=%b required %h %b",
                                 i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int b, d0, e0;
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) words[i] = DW'($urandom_range(0, 65535));
        b = got_d.size(); d0 = done_cnt; e0 = err_cnt;
        start_and_load(6, 2, 1'b0, 1'b1);
        wait_done(d0, 1'b1);
        nchk++;
        if (got_d.size() - b != 10 || done_cnt - d0 != 1 || err_cnt != e0) begin
            nerr++; $display("FAIL ignore_counts: elements=%0d done=%0d err=%0d required 10 1 0",
                             got_d.size() - b, done_cnt - d0, err_cnt - e0);
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            nchk++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                nerr++; $display("FAIL ignore_elem%0d: data=%h last=%b required %h %b",
                                 i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b, d0, len, win, bad;
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(1, 12);
            win = $urandom_range(1, len);
            rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) words[i] = DW'($urandom_range(0, 65535));
            b = got_d.size(); d0 = done_cnt;
            start_and_load(len, win, j[0], 1'b0);
            wait_done(d0, 1'b0);
            if (j == 0) begin
                // a start raised during the DONE cycle must not begin a job
                start = 1'b1; cfg_len = 4'd2; cfg_win = 4'd1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                nchk++;
                if (busy !== 1'b0 || err !== 1'b0) begin
                    nerr++; $display("FAIL b2b_done_start: busy=%b err=%b required 0 0", busy, err);
                end
            end
            nchk++;
            if (got_d.size() - b != exp_d.size()) begin
                nerr++; $display("FAIL b2b%0d_count: got %0d required %0d", j, got_d.size() - b, exp_d.size());
            end
            bad = 0;
            for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++)
                if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) bad++;
            nchk++;
            if (bad != 0) begin
                nerr++; $display("FAIL b2b%0d_stream: len=%0d win=%0d wrong elements %0d required 0", j, len, win, bad);
            end
        end
        nchk++;
        if (stab_viol != 0) begin nerr++; $display("FAIL b2b_stable: %0d changes while stalled, required 0", stab_viol); end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_window();
        test_invalid();
        test_stall();
        test_reset_midjob();
        test_ignored_start();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
